// File: rtl/psram_controller.sv
// 32-bit bus to 16-bit async PSRAM bridge: each word access is split into a low and
// a high halfword phase of ACCESS_CYCLES clocks, separated by a one-clock bus turnaround.
module psram_controller #(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [20:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        psram_cen,
  output logic        psram_wen,
  output logic        psram_oen,
  output logic        psram_lbn,
  output logic        psram_ubn,
  output logic [21:0] psram_a,
  inout  wire  [15:0] psram_d
);

  typedef enum logic [2:0] {IDLE, ACC_LO, GAP, ACC_HI, ACK} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] rlo_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        cen_q, wen_q, oen_q, lbn_q, ubn_q;
  logic [21:0] a_q;
  logic [15:0] dout_q;
  logic        drv_q;

  // All pins come straight from flops so they are glitch-free and constant per phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      {cen_q, wen_q, oen_q, lbn_q, ubn_q} <= '1;
      a_q     <= '0;
      dout_q  <= '0;
      drv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (stb_i && cyc_i) begin
            we_q    <= we_i;
            sel_q   <= sel_i;
            addr_q  <= addr_i;
            wdata_q <= data_i;
            if (we_i && sel_i == 4'b0000) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else if (we_i && sel_i[1:0] == 2'b00) begin
              state_q <= GAP;
            end else begin
              state_q <= ACC_LO;
              cnt_q   <= CNT_LOAD;
              cen_q   <= 1'b0;
              wen_q   <= ~we_i;
              oen_q   <= we_i;
              lbn_q   <= we_i & ~sel_i[0];
              ubn_q   <= we_i & ~sel_i[1];
              a_q     <= {addr_i, 1'b0};
              dout_q  <= data_i[15:0];
              drv_q   <= we_i;
            end
          end
        end

        ACC_LO: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!we_q) rlo_q <= psram_d;
            state_q <= GAP;
            {cen_q, wen_q, oen_q, lbn_q, ubn_q} <= '1;
            drv_q   <= 1'b0;
          end
        end

        GAP: begin
          if (we_q && sel_q[3:2] == 2'b00) begin
            state_q <= ACK;
            ack_q   <= cyc_i;
          end else begin
            state_q <= ACC_HI;
            cnt_q   <= CNT_LOAD;
            cen_q   <= 1'b0;
            wen_q   <= ~we_q;
            oen_q   <= we_q;
            lbn_q   <= we_q & ~sel_q[2];
            ubn_q   <= we_q & ~sel_q[3];
            a_q     <= {addr_q, 1'b1};
            dout_q  <= wdata_q[31:16];
            drv_q   <= we_q;
          end
        end

        ACC_HI: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Both halves land in data_o together so it only changes on entry to ACK.
            if (!we_q) rdata_q <= {psram_d, rlo_q};
            state_q <= ACK;
            ack_q   <= cyc_i;
            {cen_q, wen_q, oen_q, lbn_q, ubn_q} <= '1;
            drv_q   <= 1'b0;
          end
        end

        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o    = rdata_q;
  assign ack_o     = ack_q;
  assign psram_cen = cen_q;
  assign psram_wen = wen_q;
  assign psram_oen = oen_q;
  assign psram_lbn = lbn_q;
  assign psram_ubn = ubn_q;
  assign psram_a   = a_q;
  assign psram_d   = drv_q ? dout_q : 16'hzzzz;

endmodule
